xor_checksum_accum: RTL and testbench
=====================================

# xor_checksum_accum

Parametrised, frame-based XOR checksum engine. It accepts a stream of WIDTH-bit words over a valid/ready handshake and folds each frame into a running XOR. On the frame's last word it presents the checksum, its parity bit, the word count and an overflow flag on a held output register with its own valid/ready handshake. It generalises the two-input XOR gate into a sequential, back-pressured datapath block, and sits between a word source and any integrity-check consumer.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- MAX_LEN, 16: maximum words per frame counted; count saturates here (≥1).
- CNT_W, $clog2(MAX_LEN+1): derived width of length output; not to be overridden.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort of partial frame and pending result.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to fold.
- in_last  input  1  marks final word of frame.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  XOR of all words in frame.
- out_parity  output  1  reduction XOR of out_sum.
- out_len  output  CNT_W  words in frame, saturated at MAX_LEN.
- out_err  output  1  frame had more than MAX_LEN words.

## Operation
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = ~clear & (~out_valid | out_ready): a new word, including a last word, may be accepted in the same cycle as the held result is taken.
- Internal state: acc[WIDTH], cnt[CNT_W], ovf, first flag (1 = no word yet in current frame).
- Accepted word, first=1: acc←in_data, cnt←1, ovf←0, first←0.
- Accepted word, first=0: acc←acc^in_data. cnt←cnt+1 if cnt<MAX_LEN, else hold and set ovf←1.
- Accepted word with in_last=1: out_sum←folded value including this word. out_len and out_err are computed the same way. out_parity←^folded value. out_valid←1. first←1.
- Output transfer without a new last word: out_valid←0. out_sum, out_len, out_err and out_parity retain their last values.
- Output registers change only on an accepted last word, clear, or reset. They are stable while out_valid=1 and out_ready=0.
- clear=1: at the next edge first←1, acc←0, cnt←0, ovf←0, out_valid←0. The input is ignored that cycle (in_ready=0). The data outputs are zeroed.
- No states beyond first/out_valid. Effective FSM:
  - IDLE (first=1, out_valid=0)
  - ACCUM (first=0)
  - HOLD (out_valid=1)
  - HOLD and ACCUM may overlap, because the next frame may begin accumulating while the result waits.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_sum=0, out_parity=0, out_len=0, out_err=0, acc=0, cnt=0, first=1. in_ready=1 once rst_n=1 and clear=0.
- Latency: out_valid rises on the edge that accepts the last word, so it is visible the cycle after the in_last handshake.
- Throughput: one word per cycle sustained, including back-to-back single-word frames while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. The source must hold in_valid/in_data/in_last stable until accepted.
- Simultaneous output transfer and last-word accept: the new result replaces the old one and out_valid stays 1.
- clear overrides all handshakes in the same cycle. rst_n overrides clear.
- Reset mid-frame discards the partial frame. No result is emitted.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately. After release, in_ready=1 and out_valid=0.
- Frame 0x5A, 0xFF, 0x0F(last), out_ready=1 -> one cycle after last: out_valid=1, out_sum=0xAA, out_parity=0, out_len=3, out_err=0.
- Back-to-back single-word frames 0x01(last), 0x80(last) on consecutive cycles, out_ready=1 -> results 0x01/parity 1/len 1, then 0x80/parity 1/len 1, on consecutive cycles with in_ready continuously 1.
- Backpressure: result 0x3C pending with out_ready=0, next last word presented -> in_ready=0 and outputs stable for 5 cycles. Raise out_ready -> 0x3C transfers and the new word is accepted in the same cycle.
- Overflow (MAX_LEN=4): six words 0x01, 0x02, 0x04, 0x08, 0x10, 0x20(last) -> out_sum=0x3F, out_len=4, out_err=1, out_parity=0.
- clear after two words of a frame, then frame 0x11, 0x22(last) -> out_sum=0x33 and out_len=2, with no contamination from the aborted words. clear while out_valid=1 -> out_valid=0 at the next edge.

Source files
------------

// File: rtl/xor_checksum_accum.sv
// Frame-based XOR checksum engine. It folds valid/ready words into a running XOR and
// presents sum, parity, length and overflow on a held result register.
module xor_checksum_accum #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_len,
   output logic             out_err
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_LEN);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             first_q, first_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic             out_parity_q, out_parity_d;
   logic [CNT_W-1:0] out_len_q, out_len_d;
   logic             out_err_q, out_err_d;

   logic             in_fire, out_fire;
   logic [WIDTH-1:0] fold_acc;
   logic [CNT_W-1:0] fold_cnt;
   logic             fold_ovf;

   // Frame state as it would stand after folding the word currently offered.
   always_comb begin
      fold_acc = acc_q ^ in_data;
      fold_cnt = cnt_q;
      fold_ovf = ovf_q;
      if (first_q) begin
         fold_acc = in_data;
         fold_cnt = CNT_W'(1);
         fold_ovf = 1'b0;
      end else if (cnt_q < MaxCnt) begin
         fold_cnt = cnt_q + CNT_W'(1);
      end else begin
         fold_ovf = 1'b1;
      end
   end

   always_comb begin
      in_ready     = ~clear & (~out_valid_q | out_ready);
      in_fire      = in_valid & in_ready;
      out_fire     = out_valid_q & out_ready;

      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      first_d      = first_q;
      out_valid_d  = out_valid_q;
      out_sum_d    = out_sum_q;
      out_parity_d = out_parity_q;
      out_len_d    = out_len_q;
      out_err_d    = out_err_q;

      if (clear) begin
         acc_d        = '0;
         cnt_d        = '0;
         ovf_d        = 1'b0;
         first_d      = 1'b1;
         out_valid_d  = 1'b0;
         out_sum_d    = '0;
         out_parity_d = 1'b0;
         out_len_d    = '0;
         out_err_d    = 1'b0;
      end else begin
         if (out_fire) begin
            out_valid_d = 1'b0;
         end
         if (in_fire) begin
            acc_d   = fold_acc;
            cnt_d   = fold_cnt;
            ovf_d   = fold_ovf;
            first_d = in_last;
            // A last word taken alongside an output transfer replaces the result.
            if (in_last) begin
               out_valid_d  = 1'b1;
               out_sum_d    = fold_acc;
               out_parity_d = ^fold_acc;
               out_len_d    = fold_cnt;
               out_err_d    = fold_ovf;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         first_q      <= 1'b1;
         out_valid_q  <= 1'b0;
         out_sum_q    <= '0;
         out_parity_q <= 1'b0;
         out_len_q    <= '0;
         out_err_q    <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         first_q      <= first_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_parity_q <= out_parity_d;
         out_len_q    <= out_len_d;
         out_err_q    <= out_err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sum    = out_sum_q;
   assign out_parity = out_parity_q;
   assign out_len    = out_len_q;
   assign out_err    = out_err_q;

endmodule

// File: tb/tb_xor_checksum_accum.sv
// Bench for xor_checksum_accum (MAX_LEN=4): directed scenarios plus a randomized run
// scored against a frame-level reference model.
module tb_xor_checksum_accum;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_parity;
   logic [CNT_W-1:0] out_len;
   logic             out_err;

   int total = 0;
   int bad   = 0;

   xor_checksum_accum #(
      .WIDTH  (WIDTH),
      .MAX_LEN(MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_parity(out_parity),
      .out_len   (out_len),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Starts and ends at a falling edge; leaves in_valid asserted for the caller.
   task automatic send(input logic [WIDTH-1:0] d, input logic l);
      bit ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (in_ready === 1'b1) begin
            ok = 1;
            @(posedge clk);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_timeout got=no_accept exp=accept data=%h", d);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00) begin
         bad++;
         $display("FAIL reset_release got=rdy%b v%b s%h exp=rdy1 v0 s00",
                  in_ready, out_valid, out_sum);
      end
      @(negedge clk);
      out_ready = 1'b1;
      send(8'h5A, 1'b1);
      send(8'h77, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, out_sum, out_parity, out_len, out_err} !== '0) begin
         bad++;
         $display("FAIL reset_async got=v%b s%h p%b l%0d e%b exp=all0",
                  out_valid, out_sum, out_parity, out_len, out_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_after got=rdy%b v%b exp=rdy1 v0", in_ready, out_valid);
      end
      @(negedge clk);
      send(8'h01, 1'b1);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_sum !== 8'h01 || out_len !== 3'd1) begin
         bad++;
         $display("FAIL reset_discard got=v%b s%h l%0d exp=v1 s01 l1",
                  out_valid, out_sum, out_len);
      end
      @(negedge clk);
   endtask

   task automatic test_frame();
      out_ready = 1'b1;
      send(8'h5A, 1'b0);
      send(8'hFF, 1'b0);
      send(8'h0F, 1'b1);
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_sum, out_parity, out_len, out_err} !== {1'b1, 8'hAA, 1'b0, 3'd3, 1'b0})
      begin
         bad++;
         $display("FAIL frame_basic got=v%b s%h p%b l%0d e%b exp=v1 sAA p0 l3 e0",
                  out_valid, out_sum, out_parity, out_len, out_err);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_sum !== 8'hAA) begin
         bad++;
         $display("FAIL frame_taken got=v%b s%h exp=v0 sAA", out_valid, out_sum);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send(8'h01, 1'b1);
      total++;
      if ({out_valid, out_sum, out_parity, out_len} !== {1'b1, 8'h01, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL b2b_first got=v%b s%h p%b l%0d exp=v1 s01 p1 l1",
                  out_valid, out_sum, out_parity, out_len);
      end
      in_data = 8'h80;
      in_last = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ready got=%b exp=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_sum, out_parity, out_len} !== {1'b1, 8'h80, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL b2b_second got=v%b s%h p%b l%0d exp=v1 s80 p1 l1",
                  out_valid, out_sum, out_parity, out_len);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(8'h3C, 1'b1);
      in_data = 8'h55;
      in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'h3C || out_len !== 3'd1)
         begin
            bad++;
            $display("FAIL bp_hold%0d got=rdy%b v%b s%h l%0d exp=rdy0 v1 s3C l1",
                     i, in_ready, out_valid, out_sum, out_len);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release got=%b exp=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_sum, out_parity, out_len} !== {1'b1, 8'h55, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL bp_replace got=v%b s%h p%b l%0d exp=v1 s55 p0 l1",
                  out_valid, out_sum, out_parity, out_len);
      end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] w;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w = 8'h01 << i;
         send(w, i == 5);
      end
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_sum, out_parity, out_len, out_err} !== {1'b1, 8'h3F, 1'b0, 3'd4, 1'b1})
      begin
         bad++;
         $display("FAIL overflow got=v%b s%h p%b l%0d e%b exp=v1 s3F p0 l4 e1",
                  out_valid, out_sum, out_parity, out_len, out_err);
      end
      @(negedge clk);
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      clear = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL clear_ready got=%b exp=0", in_ready);
      end
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      send(8'h11, 1'b0);
      out_ready = 1'b0;
      send(8'h22, 1'b1);
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_sum, out_len, out_err} !== {1'b1, 8'h33, 3'd2, 1'b0}) begin
         bad++;
         $display("FAIL clear_clean got=v%b s%h l%0d e%b exp=v1 s33 l2 e0",
                  out_valid, out_sum, out_len, out_err);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_len !== 3'd0) begin
         bad++;
         $display("FAIL clear_held got=v%b s%h l%0d exp=v0 s00 l0", out_valid, out_sum, out_len);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] frame[$];
      logic [WIDTH-1:0] word = '0, x_sum = '0, sum;
      logic             last = 1'b0, pend = 1'b0, hv = 1'b0, x_err = 1'b0, exp_rdy;
      int unsigned      x_len = 0, n;
      for (int cyc = 0; cyc < 600; cyc++) begin
         total++;
         if (out_valid !== hv) begin
            bad++;
            $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, hv);
         end else if (hv) begin
            total++;
            if (out_sum !== x_sum || out_len !== CNT_W'(x_len) || out_err !== x_err ||
                out_parity !== 1'($countones(x_sum) % 2)) begin
               bad++;
               $display("FAIL rnd_result cyc=%0d got=s%h l%0d e%b p%b exp=s%h l%0d e%b",
                        cyc, out_sum, out_len, out_err, out_parity, x_sum, x_len, x_err);
            end
         end
         if (!pend && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            word = WIDTH'($urandom);
            last = ($urandom_range(0, 3) == 0) || (frame.size() >= 6);
         end
         in_valid  = pend;
         in_data   = word;
         in_last   = last;
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_rdy = !hv || out_ready;
         total++;
         if (in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
         end
         if (hv && out_ready) hv = 1'b0;
         if (pend && exp_rdy) begin
            frame.push_back(word);
            pend = 1'b0;
            if (last) begin
               sum = '0;
               foreach (frame[k]) sum ^= frame[k];
               n     = frame.size();
               x_sum = sum;
               x_len = (n > MAX_LEN) ? MAX_LEN : n;
               x_err = (n > MAX_LEN);
               hv    = 1'b1;
               frame.delete();
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
